// File: rtl/core_load_pkg.sv
// Shared types and constants for the boot loader: FSM states, restart byte, default halt encoding.
package core_load_pkg;

  typedef enum logic [2:0] {
    HDR,
    LOAD,
    RUN,
    HALTED,
    ERR
  } state_t;

  localparam logic [7:0]  RESTART_BYTE       = 8'hA5;
  localparam logic [31:0] HALT_INSTR_DEFAULT = 32'h0000006F;

endpackage

// File: rtl/byte_word_assembler.sv
// Little-endian 4-byte packer; word/word_done are combinational on the 4th byte so the caller
// can act in the same cycle. Bytes are consumed whenever byte_en is high (no backpressure of its own).
module byte_word_assembler (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  byte_data,
  output logic [31:0] word,
  output logic        word_done
);

  logic [31:0] shreg;
  logic [1:0]  cnt;

  // Shift in from the top so the first byte lands in bits [7:0] after four bytes.
  assign word      = {byte_data, shreg[31:8]};
  assign word_done = byte_en && (cnt == 2'd3);

  always_ff @(posedge clk) begin
    if (!reset) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (clear) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (byte_en) begin
      shreg <= word;
      cnt   <= cnt + 2'd1;
    end
  end

endmodule

// File: rtl/core_load_controller.sv
// Boot sequencer: loads a length-prefixed program into imem with the core held in reset, then runs it
// until the halt idiom. One registered imem write per word; rx_ready drops only while the core runs.
module core_load_controller
  import core_load_pkg::*;
#(
  parameter int          IMEM_WORDS = 256,
  parameter int          ADDR_W     = 8,
  parameter logic [31:0] HALT_INSTR = HALT_INSTR_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic [31:0]       instr,
  input  logic [31:0]       PC_out,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_reset,
  output logic              halted,
  output logic              load_err,
  output logic [31:0]       halt_pc,
  output logic [31:0]       cycle_count
);

  localparam logic [ADDR_W-1:0] IDX_ONE = 1;

  state_t            state, state_next;
  logic              accept, asm_en, asm_clear, asm_done;
  logic [31:0]       asm_word;
  logic              hdr_bad, last_write, is_halt, restart;
  logic [ADDR_W-1:0] word_idx, last_idx;

  assign accept     = rx_valid && rx_ready;
  assign asm_en     = accept && (state == HDR || state == LOAD);
  assign asm_clear  = (state_next != state);
  assign hdr_bad    = (asm_word == 32'd0) || (asm_word > 32'(IMEM_WORDS));
  assign last_write = imem_we && (imem_addr == last_idx);
  assign is_halt    = (instr == HALT_INSTR);
  assign restart    = accept && (rx_data == RESTART_BYTE);

  byte_word_assembler u_asm (
    .clk       (clk),
    .reset     (reset),
    .clear     (asm_clear),
    .byte_en   (asm_en),
    .byte_data (rx_data),
    .word      (asm_word),
    .word_done (asm_done)
  );

  always_ff @(posedge clk) begin
    if (!reset) state <= HDR;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    rx_ready   = (state != RUN);
    core_reset = !(state == RUN || state == HALTED);
    halted     = (state == HALTED);
    load_err   = (state == ERR);
    case (state)
      HDR:     if (asm_done) state_next = hdr_bad ? ERR : LOAD;
      // Leave LOAD only after the final write cycle so the core never fetches a half-written image.
      LOAD:    if (last_write) state_next = RUN;
      RUN:     if (is_halt) state_next = HALTED;
      HALTED:  if (restart) state_next = HDR;
      ERR:     state_next = ERR;
      default: state_next = HDR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      imem_we     <= 1'b0;
      imem_addr   <= '0;
      imem_wdata  <= '0;
      halt_pc     <= '0;
      cycle_count <= '0;
      word_idx    <= '0;
      last_idx    <= '0;
    end else begin
      imem_we <= 1'b0;
      case (state)
        HDR: begin
          if (asm_done && !hdr_bad) begin
            word_idx <= '0;
            last_idx <= asm_word[ADDR_W-1:0] - IDX_ONE;
          end
        end
        LOAD: begin
          if (asm_done) begin
            imem_we    <= 1'b1;
            imem_addr  <= word_idx;
            imem_wdata <= asm_word;
            word_idx   <= word_idx + IDX_ONE;
          end
        end
        RUN: begin
          cycle_count <= cycle_count + 32'd1;
          if (is_halt) halt_pc <= PC_out;
        end
        HALTED: begin
          if (restart) cycle_count <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_core_load_controller.sv
// Directed bench with a toy core model; writes and halts are checked by a queue-driven monitor.
module tb_core_load_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [31:0] instr, PC_out;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        core_reset, halted, load_err;
  logic [31:0] halt_pc, cycle_count;

  core_load_controller dut (
    .clk         (clk),
    .reset       (reset),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .instr       (instr),
    .PC_out      (PC_out),
    .imem_we     (imem_we),
    .imem_addr   (imem_addr),
    .imem_wdata  (imem_wdata),
    .core_reset  (core_reset),
    .halted      (halted),
    .load_err    (load_err),
    .halt_pc     (halt_pc),
    .cycle_count (cycle_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Toy core: fetch from the bench's imem, step PC by 4, spin on the self-jump.
  logic [31:0] mem [0:255];
  logic [31:0] pc = 32'd0;
  initial for (int i = 0; i < 256; i++) mem[i] = 32'd0;
  assign instr  = mem[pc[9:2]];
  assign PC_out = pc;
  always @(posedge clk) begin
    if (imem_we) mem[imem_addr] <= imem_wdata;
    if (core_reset) pc <= 32'd0;
    else if (instr != 32'h0000006F) pc <= pc + 32'd4;
  end

  // Scoreboard queues: {addr, data} per write, {halt_pc, cycle_count} per halt.
  logic [39:0] wq[$];
  logic [63:0] hq[$];
  int cyc = 0, we_count = 0, last_we_cyc = -10, fall_cyc = -20;
  logic prev_we = 1'b0, prev_halted = 1'b0, prev_cr = 1'b1;

  always @(negedge clk) begin
    logic [39:0] we_e;
    logic [63:0] h_e;
    cyc++;
    if (imem_we) begin
      we_count++;
      last_we_cyc = cyc;
      check("we_single_cycle", 32'(prev_we), 32'd0);
      if (wq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL we_unexpected: got write addr=%h data=%h, none expected", imem_addr, imem_wdata);
      end else begin
        we_e = wq.pop_front();
        check("we_addr", 32'(imem_addr), 32'(we_e[39:32]));
        check("we_data", imem_wdata, we_e[31:0]);
      end
    end
    if (halted && !prev_halted) begin
      if (hq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL halt_unexpected: got halt at pc=%h, none expected", halt_pc);
      end else begin
        h_e = hq.pop_front();
        check("halt_pc", halt_pc, h_e[63:32]);
        check("halt_cycles", cycle_count, h_e[31:0]);
      end
    end
    if (prev_cr && !core_reset) fall_cyc = cyc;
    prev_we     = imem_we;
    prev_halted = halted;
    prev_cr     = core_reset;
  end

  task automatic send_byte(input logic [7:0] b);
    logic ok;
    ok = 1'b0;
    rx_data  = b;
    rx_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      ok = rx_ready;
      @(posedge clk);
      #1;
      if (ok) break;
    end
    rx_valid = 1'b0;
    check("byte_accepted", 32'(ok), 32'd1);
  endtask

  task automatic idle(input int n);
    rx_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [31:0] w, input logic gaps);
    for (int k = 0; k < 4; k++) begin
      send_byte(w[8*k +: 8]);
      if (gaps) idle((k % 3) + 1);
    end
  endtask

  task automatic exp_write(input logic [7:0] a, input logic [31:0] d);
    wq.push_back({a, d});
  endtask

  task automatic wait_halt();
    for (int i = 0; i < 2000; i++) begin
      if (halted) break;
      @(posedge clk);
      #1;
    end
    check("halt_reached", 32'(halted), 32'd1);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  initial begin
    int wc;
    logic [31:0] w;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_rx_ready", 32'(rx_ready), 32'd1);
    check("rst_core_reset", 32'(core_reset), 32'd1);
    check("rst_imem_we", 32'(imem_we), 32'd0);
    check("rst_imem_addr", 32'(imem_addr), 32'd0);
    check("rst_imem_wdata", imem_wdata, 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_load_err", 32'(load_err), 32'd0);
    check("rst_halt_pc", halt_pc, 32'd0);
    check("rst_cycle_count", cycle_count, 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;

    // Two-word program: addi, then halt at PC 4
    exp_write(8'd0, 32'h00500093);
    exp_write(8'd1, 32'h0000006F);
    hq.push_back({32'd4, 32'd2});
    send_word(32'd2, 1'b0);
    send_word(32'h00500093, 1'b0);
    send_word(32'h0000006F, 1'b0);
    wait_halt();
    check("release_after_last_we", 32'(fall_cyc), 32'(last_we_cyc + 1));
    check("mem0", mem[0], 32'h00500093);
    check("mem1", mem[1], 32'h0000006F);

    // HALTED: non-restart byte ignored, restart byte returns to HDR
    send_byte(8'h11);
    check("h11_halted", 32'(halted), 32'd1);
    check("h11_cycles", cycle_count, 32'd2);
    check("h11_core_reset", 32'(core_reset), 32'd0);
    send_byte(8'hA5);
    check("a5_halted", 32'(halted), 32'd0);
    check("a5_core_reset", 32'(core_reset), 32'd1);
    check("a5_cycles", cycle_count, 32'd0);
    check("a5_rx_ready", 32'(rx_ready), 32'd1);

    // Reload: halt at PC 0 on first RUN cycle
    exp_write(8'd0, 32'h0000006F);
    hq.push_back({32'd0, 32'd1});
    send_word(32'd1, 1'b0);
    send_word(32'h0000006F, 1'b0);
    wait_halt();

    // Gapped byte stream reproduces the same image, one pulse per word
    send_byte(8'hA5);
    wc = we_count;
    exp_write(8'd0, 32'h00500093);
    exp_write(8'd1, 32'h0000006F);
    hq.push_back({32'd4, 32'd2});
    send_word(32'd2, 1'b1);
    send_word(32'h00500093, 1'b1);
    send_word(32'h0000006F, 1'b1);
    wait_halt();
    check("gap_we_count", 32'(we_count - wc), 32'd2);
    check("gap_mem0", mem[0], 32'h00500093);

    // Reset mid-load, then clean one-word load
    do_reset();
    exp_write(8'd0, 32'h11223344);
    send_word(32'd2, 1'b0);
    send_word(32'h11223344, 1'b0);
    send_byte(8'hAA);
    send_byte(8'hBB);
    do_reset();
    check("abort_core_reset", 32'(core_reset), 32'd1);
    exp_write(8'd0, 32'h0000006F);
    hq.push_back({32'd0, 32'd1});
    send_word(32'd1, 1'b0);
    send_word(32'h0000006F, 1'b0);
    wait_halt();
    check("abort_mem0", mem[0], 32'h0000006F);

    // Zero-length header -> ERR, bytes swallowed, no writes
    do_reset();
    send_word(32'd0, 1'b0);
    check("n0_load_err", 32'(load_err), 32'd1);
    check("n0_core_reset", 32'(core_reset), 32'd1);
    wc = we_count;
    send_byte(8'h6F);
    send_byte(8'h00);
    send_byte(8'hA5);
    idle(3);
    check("n0_still_err", 32'(load_err), 32'd1);
    check("n0_no_we", 32'(we_count - wc), 32'd0);
    do_reset();
    check("n0_cleared", 32'(load_err), 32'd0);

    // Oversize header
    send_word(32'd257, 1'b0);
    check("n257_load_err", 32'(load_err), 32'd1);
    do_reset();

    // Full-depth program: 255 nops then halt at the last word
    for (int i = 0; i < 256; i++) begin
      w = (i == 255) ? 32'h0000006F : 32'h00000013;
      exp_write(8'(i), w);
    end
    hq.push_back({32'd1020, 32'd256});
    send_word(32'd256, 1'b0);
    for (int i = 0; i < 256; i++) begin
      w = (i == 255) ? 32'h0000006F : 32'h00000013;
      send_word(w, 1'b0);
    end
    wait_halt();
    check("full_release_after_last_we", 32'(fall_cyc), 32'(last_we_cyc + 1));
    check("full_mem255", mem[255], 32'h0000006F);

    idle(3);
    check("writes_outstanding", 32'(wq.size()), 32'd0);
    check("halts_outstanding", 32'(hq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
